// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding a 16-bit instruction register.
// Owns the PC and drives the instruction-memory address. Hands the IR its next
// word together with the load and NOP-insert (flush) controls. Handles stalls,
// taken-branch redirects with a programmable bubble count, and a HALT word that
// parks fetch until resume.
//
// Ports:
//   CLK, RST    clock (rising edge) and async active-high reset
//   stall       hold PC and suppress IR load
//   br_taken    taken branch from EX; br_target is the redirect address
//   resume      leave HALT and continue at PC+PC_STEP
//   imem_addr   instruction-memory address (the PC register)
//   imem_data   asynchronous read data for imem_addr
//   if_instr    word for the IR (NOP_INSTR while flushing)
//   if_pc       address of if_instr
//   if_load     IR load enable
//   if_flush    IR NOP insert
//   halted      high while parked in HALT
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned PC_STEP      = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [15:0] HALT_INSTR   = 16'hFFFF,
  parameter logic [15:0] NOP_INSTR    = 16'h001F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        resume,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_load,
  output logic        if_flush,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [15:0] STEP = 16'(PC_STEP);
  // The redirect cycle is the first bubble, so FLUSH covers the remaining ones.
  localparam logic [3:0]  BCNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
  localparam logic        MULTI_BUBBLE = (FLUSH_CYCLES > 1);

  logic [15:0] pc_q, pc_d;
  state_t      state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        run;

  // Next-state logic: branch beats stall beats HALT detection beats increment.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (br_taken) begin
      pc_d = br_target;
      if (MULTI_BUBBLE) begin
        state_d = ST_FLUSH;
        bcnt_d  = BCNT_INIT;
      end else begin
        state_d = ST_RUN;
        bcnt_d  = 4'd0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stall) begin
            pc_d = pc_q;
          end else if (imem_data == HALT_INSTR) begin
            state_d = ST_HALT;
          end else begin
            pc_d = pc_q + STEP;
          end
        end
        ST_FLUSH: begin
          if (bcnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            bcnt_d = bcnt_q - 4'd1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            pc_d    = pc_q + STEP;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      bcnt_q  <= 4'd0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // IR controls are combinational; RST gating keeps them quiet during reset.
  assign run       = (state_q == ST_RUN);
  assign if_flush  = ~RST & (br_taken | ~run);
  assign if_load   = ~RST & run & ~stall & ~br_taken;
  assign if_instr  = if_flush ? NOP_INSTR : imem_data;
  assign halted    = (state_q == ST_HALT);
  assign imem_addr = pc_q;
  assign if_pc     = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with FLUSH_CYCLES = 3.
// Memory model: imem[n] = n + 16'h0100, except imem[halt_at] = 16'hFFFF when enabled.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        resume = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_load;
  logic        if_flush;
  logic        halted;

  logic        halt_en = 1'b0;
  logic [15:0] halt_at = 16'h0003;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(
    .RESET_PC    (16'h0000),
    .PC_STEP     (1),
    .FLUSH_CYCLES(3),
    .HALT_INSTR  (16'hFFFF),
    .NOP_INSTR   (16'h001F)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .stall    (stall),
    .br_taken (br_taken),
    .br_target(br_target),
    .resume   (resume),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_load  (if_load),
    .if_flush (if_flush),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  assign imem_data = (halt_en && imem_addr == halt_at) ? 16'hFFFF : imem_addr + 16'h0100;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expect a normal fetch of imem[pc] = pc + 0x100.
  task automatic expect_load(input string tag, input logic [15:0] pc);
    check({tag, "_pc"},    if_pc, pc);
    check({tag, "_load"},  16'(if_load), 16'd1);
    check({tag, "_flush"}, 16'(if_flush), 16'd0);
    check({tag, "_instr"}, if_instr, pc + 16'h0100);
  endtask

  // Expect a NOP bubble with the PC parked at pc.
  task automatic expect_nop(input string tag, input logic [15:0] pc);
    check({tag, "_pc"},    imem_addr, pc);
    check({tag, "_load"},  16'(if_load), 16'd0);
    check({tag, "_flush"}, 16'(if_flush), 16'd1);
    check({tag, "_instr"}, if_instr, 16'h001F);
  endtask

  initial begin
    // Reset values while RST is held.
    #3;
    check("rst_addr",   imem_addr, 16'h0000);
    check("rst_pc",     if_pc, 16'h0000);
    check("rst_load",   16'(if_load), 16'd0);
    check("rst_flush",  16'(if_flush), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_instr",  if_instr, 16'h0100);

    // Release between edges; sequential fetch 0..5.
    #9 RST = 1'b0;
    #1;
    expect_load("seq0", 16'h0000);
    tick(); expect_load("seq1", 16'h0001);
    tick(); expect_load("seq2", 16'h0002);
    tick(); tick(); tick();
    check("at5", if_pc, 16'h0005);

    // Two-cycle stall at PC 5.
    stall = 1'b1; #1;
    check("stall1_load", 16'(if_load), 16'd0);
    check("stall1_pc",   if_pc, 16'h0005);
    tick();
    check("stall2_load", 16'(if_load), 16'd0);
    check("stall2_pc",   if_pc, 16'h0005);
    tick(); stall = 1'b0; #1;
    expect_load("after_stall", 16'h0005);
    tick(); tick(); tick();
    check("at8", if_pc, 16'h0008);

    // Branch to 0x40 at PC 8 together with stall: redirect wins, 3 bubbles.
    br_taken = 1'b1; br_target = 16'h0040; stall = 1'b1; #1;
    expect_nop("br_b1", 16'h0008);
    tick(); br_taken = 1'b0; stall = 1'b0; #1;
    expect_nop("br_b2", 16'h0040);
    stall = 1'b1; #1;
    check("br_b2_stall_ign", 16'(if_flush), 16'd1);
    tick(); stall = 1'b0; #1;
    expect_nop("br_b3", 16'h0040);
    tick(); expect_load("br_tgt", 16'h0040);

    // Branch, then re-branch in the 2nd bubble: count restarts.
    tick(); br_taken = 1'b1; br_target = 16'h0080; #1;
    expect_nop("rb_b1", 16'h0041);
    tick(); br_target = 16'h0090; #1;
    expect_nop("rb_b2_rebr", 16'h0080);
    tick(); br_taken = 1'b0; #1;
    expect_nop("rb_n2", 16'h0090);
    tick(); expect_nop("rb_n3", 16'h0090);
    tick(); expect_load("rb_tgt", 16'h0090);

    // Branch to 0, then HALT word at address 3.
    tick(); br_taken = 1'b1; br_target = 16'h0000; halt_en = 1'b1; #1;
    tick(); br_taken = 1'b0; #1;
    tick(); tick(); expect_load("h0", 16'h0000);
    tick(); tick(); tick();
    check("halt_word",   if_instr, 16'hFFFF);
    check("halt_wload",  16'(if_load), 16'd1);
    check("halt_wflush", 16'(if_flush), 16'd0);
    check("halt_wpc",    if_pc, 16'h0003);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted",    16'(halted), 16'd1);
      check("halt_pc",   imem_addr, 16'h0003);
      check("halt_nop",  if_instr, 16'h001F);
      check("halt_load", 16'(if_load), 16'd0);
    end
    resume = 1'b1; #1;
    check("resume_cyc_halted", 16'(halted), 16'd1);
    tick(); resume = 1'b0; halt_en = 1'b0; #1;
    check("resume_halted", 16'(halted), 16'd0);
    expect_load("resume_pc", 16'h0004);
    resume = 1'b1; #1;
    tick(); resume = 1'b0; #1;
    expect_load("resume_ign", 16'h0005);

    // PC wrap at 0xFFFF.
    br_taken = 1'b1; br_target = 16'hFFFF; #1;
    tick(); br_taken = 1'b0; #1;
    tick(); tick();
    expect_load("wrap_ffff", 16'hFFFF);
    tick(); expect_load("wrap_0000", 16'h0000);

    // Async reset mid-FLUSH.
    br_taken = 1'b1; br_target = 16'h0050; #1;
    tick(); br_taken = 1'b0; #1;
    check("pre_rst_flush", 16'(if_flush), 16'd1);
    RST = 1'b1; #1;
    check("arst_addr",   imem_addr, 16'h0000);
    check("arst_flush",  16'(if_flush), 16'd0);
    check("arst_load",   16'(if_load), 16'd0);
    check("arst_halted", 16'(halted), 16'd0);
    check("arst_instr",  if_instr, 16'h0100);
    #10 RST = 1'b0;
    #1;
    check("post_rst_pc", if_pc, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
